mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: extra memory cycles per access (0..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have CPU-side ports: cpu_rd in 1, cpu_wr in 1 (level requests); cpu_byt in 1; cpu_addr in 16; cpu_wdata in 16.
REQ-005 SHALL have CPU-side outputs: cpu_rdata out 16; cpu_ack out 1 (one-cycle completion pulse); cpu_stall out 1 (holds phase sequencer).
REQ-006 SHALL have device-side ports: dev_req in 1; dev_we in 1; dev_byt in 1; dev_addr in 16; dev_wdata in 16.
REQ-007 SHALL have device-side outputs: dev_rdata out 16; dev_ack out 1 (one-cycle pulse); dev_gnt out 1 (device owns memory).
REQ-008 SHALL have memory-side ports: mem_addr out 16, mem_wdata out 16, mem_rd out 1, mem_wr out 1, mem_byt out 1, mem_rdata in 16.

Function
REQ-009 SHALL implement FSM states IDLE and ACCESS, plus owner register (CPU/DEV) and 4-bit down-counter cnt.
REQ-010 In IDLE, a requester SHALL be eligible if its request is high and its ack is low this cycle (prevents regrant on the ack cycle).
REQ-011 In IDLE with an eligible requester, posedge SHALL latch owner, addr, wdata, byt, direction; set cnt=WAIT_CYCLES; go to ACCESS.
REQ-012 CPU direction: cpu_wr=1 selects write regardless of cpu_rd; dev_we=1 selects write.
REQ-013 In ACCESS, mem_* SHALL be driven from latched values only; mem_rd/mem_wr high per direction; both low in IDLE.
REQ-014 In ACCESS with cnt!=0, cnt SHALL decrement; with cnt==0, posedge SHALL capture mem_rdata (reads only) into owner's rdata register, pulse owner's ack next cycle, return to IDLE.
REQ-015 Latency request-sample to ack-high SHALL be WAIT_CYCLES+2 cycles; bus busy WAIT_CYCLES+1 cycles per access.
REQ-016 Requester deasserting request mid-access SHALL NOT abort; ack still pulses, data still captured.
REQ-017 cpu_rdata/dev_rdata SHALL hold last captured value until next read completes for that owner; writes leave them unchanged.
REQ-018 cpu_stall SHALL equal (cpu_rd|cpu_wr) & ~cpu_ack, combinational.
REQ-019 dev_gnt SHALL be high exactly while state==ACCESS and owner==DEV.
REQ-020 Both eligible in IDLE: winner per REQ-025/026.

Reset
REQ-021 rst_n low SHALL asynchronously force state=IDLE, cnt=0, owner=CPU, last-winner=DEV.
REQ-022 During reset: mem_rd=mem_wr=0, cpu_ack=dev_ack=0, dev_gnt=0, cpu_rdata=dev_rdata=0, mem_addr=mem_wdata=0, mem_byt=0.
REQ-023 Reset mid-ACCESS SHALL drop strobes immediately and produce no ack after release.
REQ-024 First arbitration SHALL occur on first posedge after rst_n rises.

Configuration
REQ-025 Macro MEM_ARBITER_RR_EN defined: simultaneous eligible requests SHALL go to the requester that did not win the previous grant (round-robin); last-winner updated on every grant.
REQ-026 MEM_ARBITER_RR_EN undefined: CPU SHALL always win ties; last-winner register absent.

Verification
REQ-027 WAIT_CYCLES=1, cpu_rd=1 addr 0x0100, mem_rdata=0xA5A5 -> mem_rd high 2 cycles, cpu_ack pulse 3 cycles after sample, cpu_rdata=0xA5A5, cpu_stall low with ack.
REQ-028 cpu_wr=1 addr 0x0200 wdata 0x1234 byt=1 -> mem_wr high 2 cycles with mem_addr 0x0200, mem_wdata 0x1234, mem_byt=1; cpu_rdata unchanged.
REQ-029 dev_req and cpu_rd rise together, held until ack -> RR_EN: CPU, DEV, CPU alternation; without RR_EN: CPU serviced each eligible cycle, DEV only on CPU ack cycles.
REQ-030 dev_req=1 then dropped one cycle into ACCESS -> dev_ack still pulses, dev_gnt high 2 cycles, no second grant.
REQ-031 rst_n low during ACCESS cycle 1 -> mem_rd low same cycle, no ack after release, next request serviced normally.
REQ-032 WAIT_CYCLES=0 back-to-back cpu_rd held across ack -> ack cycle not regranted; accesses spaced 3 cycles.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU-side, device-side and memory-side signals for mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the view
// of whatever drives the requests and models the memory.
interface mem_arbiter_if;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_byt;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_stall;

    logic        dev_req;
    logic        dev_we;
    logic        dev_byt;
    logic [15:0] dev_addr;
    logic [15:0] dev_wdata;
    logic [15:0] dev_rdata;
    logic        dev_ack;
    logic        dev_gnt;

    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_byt;
    logic [15:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_byt, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dev_req, dev_we, dev_byt, dev_addr, dev_wdata,
        output dev_rdata, dev_ack, dev_gnt,
        output mem_addr, mem_wdata, mem_rd, mem_wr, mem_byt,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_byt, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dev_req, dev_we, dev_byt, dev_addr, dev_wdata,
        input  dev_rdata, dev_ack, dev_gnt,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, mem_byt,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / device) arbiter in front of a single memory port.
// One access at a time: latch the winner's request, hold the memory strobe
// for WAIT_CYCLES+1 cycles, capture read data, pulse the owner's ack.
// Optional feature: define MEM_ARBITER_RR_EN for round-robin tie breaking;
// without it the CPU always wins a tie.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic       OWN_CPU   = 1'b0;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_reg, state_next;
    logic        owner_reg;          // 0 = CPU, 1 = device
    logic [3:0]  cnt_reg;
    logic [15:0] addr_reg;
    logic [15:0] wdata_reg;
    logic        byt_reg;
    logic        wr_reg;
    logic        ack_reg   [2];      // indexed by owner
    logic [15:0] rdata_reg [2];      // indexed by owner

    logic [1:0]  eligible;           // {dev, cpu}
    logic        grant;
    logic        winner;
    logic        done;

    // A requester that is being acked this cycle is not eligible, so a held
    // level request is not granted again on its own ack cycle.
    assign eligible = {bus.dev_req & ~ack_reg[1],
                       (bus.cpu_rd | bus.cpu_wr) & ~ack_reg[0]};
    assign grant    = (state_reg == IDLE) && (eligible != 2'b00);
    assign done     = (state_reg == ACCESS) && (cnt_reg == 4'd0);

`ifdef MEM_ARBITER_RR_EN
    logic last_reg;                  // owner of the most recent grant

    // Remember who won the last grant so a tie goes to the other side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (grant) begin
            last_reg <= winner;
        end
    end

    assign winner = (eligible == 2'b11) ? ~last_reg : eligible[1];
`else
    // CPU has fixed priority; the device wins only when the CPU is not eligible.
    assign winner = ~eligible[0];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: an access never aborts once started.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = ACCESS;
            ACCESS:  if (cnt_reg == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winning request and run the wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg <= OWN_CPU;
            cnt_reg   <= 4'd0;
            addr_reg  <= 16'h0000;
            wdata_reg <= 16'h0000;
            byt_reg   <= 1'b0;
            wr_reg    <= 1'b0;
        end else if (grant) begin
            owner_reg <= winner;
            cnt_reg   <= WAIT_INIT;
            addr_reg  <= winner ? bus.dev_addr  : bus.cpu_addr;
            wdata_reg <= winner ? bus.dev_wdata : bus.cpu_wdata;
            byt_reg   <= winner ? bus.dev_byt   : bus.cpu_byt;
            wr_reg    <= winner ? bus.dev_we    : bus.cpu_wr;
        end else if ((state_reg == ACCESS) && (cnt_reg != 4'd0)) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    // Per-owner completion pulse and read-data holding register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_owner
        localparam logic ID = 1'(gi);

        // Ack pulses the cycle after the final access cycle; reads update rdata.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ack_reg[gi]   <= 1'b0;
                rdata_reg[gi] <= 16'h0000;
            end else begin
                ack_reg[gi] <= done && (owner_reg == ID);
                if (done && (owner_reg == ID) && !wr_reg) begin
                    rdata_reg[gi] <= bus.mem_rdata;
                end
            end
        end
    end

    // Outputs: memory strobes only while accessing, everything else from registers.
    always_comb begin
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        if (state_reg == ACCESS) begin
            bus.mem_rd = ~wr_reg;
            bus.mem_wr = wr_reg;
        end
        bus.mem_addr  = addr_reg;
        bus.mem_wdata = wdata_reg;
        bus.mem_byt   = byt_reg;
        bus.cpu_ack   = ack_reg[0];
        bus.dev_ack   = ack_reg[1];
        bus.cpu_rdata = rdata_reg[0];
        bus.dev_rdata = rdata_reg[1];
        bus.cpu_stall = (bus.cpu_rd | bus.cpu_wr) & ~ack_reg[0];
        bus.dev_gnt   = (state_reg == ACCESS) && owner_reg;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed table, hand-written multi-cycle
// sequences and a randomized run against a timeline-based reference model.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int W = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter_if b1 ();
    mem_arbiter_if b0 ();

    mem_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mem_arbiter #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    typedef struct {
        logic        cpu_rd, cpu_wr, cpu_byt;
        logic [15:0] cpu_addr, cpu_wdata, mem_rdata;
        logic        chk_bus, e_rd, e_wr, e_byt;
        logic [15:0] e_addr, e_wdata;
        logic        e_ack, e_stall;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t tbl [10];

    // Reference model state (timeline of the current grant)
    bit          m_have;
    int          m_g;
    bit          m_own;
    bit          m_wr;
    bit          m_byt;
    bit          m_last;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] m_rdata [2];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clr_inputs();
        b1.cpu_rd = 1'b0; b1.cpu_wr = 1'b0; b1.cpu_byt = 1'b0;
        b1.cpu_addr = 16'h0; b1.cpu_wdata = 16'h0;
        b1.dev_req = 1'b0; b1.dev_we = 1'b0; b1.dev_byt = 1'b0;
        b1.dev_addr = 16'h0; b1.dev_wdata = 16'h0; b1.mem_rdata = 16'h0;
        b0.cpu_rd = 1'b0; b0.cpu_wr = 1'b0; b0.cpu_byt = 1'b0;
        b0.cpu_addr = 16'h0; b0.cpu_wdata = 16'h0;
        b0.dev_req = 1'b0; b0.dev_we = 1'b0; b0.dev_byt = 1'b0;
        b0.dev_addr = 16'h0; b0.dev_wdata = 16'h0; b0.mem_rdata = 16'h0;
    endtask

    // Reset both DUTs; returns at posedge+1 of the first cycle after release.
    task automatic do_reset();
        rst_n = 1'b0;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Check one cycle of dut1 handshake outputs, then advance to the next cycle.
    task automatic step(input string nm, input logic ea, input logic ed,
                        input logic eg, input logic er);
        @(negedge clk);
        chk1({nm, ".cpu_ack"}, b1.cpu_ack, ea);
        chk1({nm, ".dev_ack"}, b1.dev_ack, ed);
        chk1({nm, ".dev_gnt"}, b1.dev_gnt, eg);
        chk1({nm, ".mem_rd"},  b1.mem_rd,  er);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // rd wr byt addr wdata mem_rdata | chk rd wr byt addr wdata ack stall rdata
        tbl[0] = '{1'b1,1'b0,1'b0,16'h0100,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b1,16'h0000};
        tbl[1] = '{1'b1,1'b0,1'b0,16'h0100,16'h0000,16'hA5A5, 1'b1,1'b1,1'b0,1'b0,16'h0100,16'h0000, 1'b0,1'b1,16'h0000};
        tbl[2] = '{1'b1,1'b0,1'b0,16'h0100,16'h0000,16'hA5A5, 1'b1,1'b1,1'b0,1'b0,16'h0100,16'h0000, 1'b0,1'b1,16'h0000};
        tbl[3] = '{1'b1,1'b0,1'b0,16'h0100,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'hA5A5};
        tbl[4] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'hA5A5};
        tbl[5] = '{1'b0,1'b1,1'b1,16'h0200,16'h1234,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b1,16'hA5A5};
        tbl[6] = '{1'b0,1'b1,1'b1,16'h0200,16'h1234,16'hFFFF, 1'b1,1'b0,1'b1,1'b1,16'h0200,16'h1234, 1'b0,1'b1,16'hA5A5};
        tbl[7] = '{1'b0,1'b1,1'b0,16'hDEAD,16'h0000,16'hFFFF, 1'b1,1'b0,1'b1,1'b1,16'h0200,16'h1234, 1'b0,1'b1,16'hA5A5};
        tbl[8] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'hA5A5};
        tbl[9] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'hA5A5};

        // Outputs while reset is held
        clr_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst.mem_rd", b1.mem_rd, 1'b0);
        chk1("rst.mem_wr", b1.mem_wr, 1'b0);
        chk1("rst.cpu_ack", b1.cpu_ack, 1'b0);
        chk1("rst.dev_ack", b1.dev_ack, 1'b0);
        chk1("rst.dev_gnt", b1.dev_gnt, 1'b0);
        chk1("rst.mem_byt", b1.mem_byt, 1'b0);
        chk16("rst.cpu_rdata", b1.cpu_rdata, 16'h0);
        chk16("rst.dev_rdata", b1.dev_rdata, 16'h0);
        chk16("rst.mem_addr", b1.mem_addr, 16'h0);
        chk16("rst.mem_wdata", b1.mem_wdata, 16'h0);

        // Directed read then write through the table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            b1.cpu_rd = tbl[i].cpu_rd; b1.cpu_wr = tbl[i].cpu_wr; b1.cpu_byt = tbl[i].cpu_byt;
            b1.cpu_addr = tbl[i].cpu_addr; b1.cpu_wdata = tbl[i].cpu_wdata;
            b1.mem_rdata = tbl[i].mem_rdata;
            @(negedge clk);
            chk1($sformatf("tbl%0d.mem_rd", i), b1.mem_rd, tbl[i].e_rd);
            chk1($sformatf("tbl%0d.mem_wr", i), b1.mem_wr, tbl[i].e_wr);
            chk1($sformatf("tbl%0d.cpu_ack", i), b1.cpu_ack, tbl[i].e_ack);
            chk1($sformatf("tbl%0d.cpu_stall", i), b1.cpu_stall, tbl[i].e_stall);
            chk16($sformatf("tbl%0d.cpu_rdata", i), b1.cpu_rdata, tbl[i].e_rdata);
            chk1($sformatf("tbl%0d.dev_gnt", i), b1.dev_gnt, 1'b0);
            if (tbl[i].chk_bus) begin
                chk16($sformatf("tbl%0d.mem_addr", i), b1.mem_addr, tbl[i].e_addr);
                chk16($sformatf("tbl%0d.mem_wdata", i), b1.mem_wdata, tbl[i].e_wdata);
                chk1($sformatf("tbl%0d.mem_byt", i), b1.mem_byt, tbl[i].e_byt);
            end
            @(posedge clk);
            #1;
        end

        // Both requests held: alternation CPU, DEV, CPU, DEV
        do_reset();
        b1.cpu_rd = 1'b1; b1.dev_req = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c == 12) begin b1.cpu_rd = 1'b0; b1.dev_req = 1'b0; end
            step($sformatf("alt.c%0d", c), (c == 3) || (c == 9), (c == 6) || (c == 12),
                 (c == 4) || (c == 5) || (c == 10) || (c == 11),
                 (c != 0) && (c % 3 != 0));
        end
        // CPU-only access (request dropped mid-access), then a tie from idle
        b1.cpu_rd = 1'b1;  step("cpu_only.c0", 1'b0, 1'b0, 1'b0, 1'b0);
        b1.cpu_rd = 1'b0;  step("cpu_only.c1", 1'b0, 1'b0, 1'b0, 1'b1);
        step("cpu_only.c2", 1'b0, 1'b0, 1'b0, 1'b1);
        step("cpu_only.c3", 1'b1, 1'b0, 1'b0, 1'b0);
        b1.cpu_rd = 1'b1; b1.dev_req = 1'b1;
        step("tie.c0", 1'b0, 1'b0, 1'b0, 1'b0);
        b1.cpu_rd = 1'b0; b1.dev_req = 1'b0;
        step("tie.c1", 1'b0, 1'b0, RR, 1'b1);
        step("tie.c2", 1'b0, 1'b0, RR, 1'b1);
        step("tie.c3", !RR, RR, 1'b0, 1'b0);
        step("tie.c4", 1'b0, 1'b0, 1'b0, 1'b0);

        // Device request dropped one cycle into the access
        do_reset();
        b1.dev_req = 1'b1;
        step("devdrop.c0", 1'b0, 1'b0, 1'b0, 1'b0);
        b1.dev_req = 1'b0;
        step("devdrop.c1", 1'b0, 1'b0, 1'b1, 1'b1);
        b1.mem_rdata = 16'h5A5A;
        step("devdrop.c2", 1'b0, 1'b0, 1'b1, 1'b1);
        b1.mem_rdata = 16'h0000;
        step("devdrop.c3", 1'b0, 1'b1, 1'b0, 1'b0);
        step("devdrop.c4", 1'b0, 1'b0, 1'b0, 1'b0);
        chk16("devdrop.dev_rdata", b1.dev_rdata, 16'h5A5A);
        chk16("devdrop.cpu_rdata", b1.cpu_rdata, 16'h0000);

        // Reset asserted during the first access cycle
        do_reset();
        b1.cpu_rd = 1'b1; b1.mem_rdata = 16'h7777;
        step("rstmid.c0", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk1("rstmid.mem_rd_before", b1.mem_rd, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("rstmid.mem_rd_async", b1.mem_rd, 1'b0);
        b1.cpu_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) step($sformatf("rstmid.after%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
        chk16("rstmid.cpu_rdata", b1.cpu_rdata, 16'h0000);
        b1.cpu_rd = 1'b1; b1.mem_rdata = 16'h3C3C;
        step("rstmid.req.c0", 1'b0, 1'b0, 1'b0, 1'b0);
        b1.cpu_rd = 1'b0;
        step("rstmid.req.c1", 1'b0, 1'b0, 1'b0, 1'b1);
        step("rstmid.req.c2", 1'b0, 1'b0, 1'b0, 1'b1);
        step("rstmid.req.c3", 1'b1, 1'b0, 1'b0, 1'b0);
        chk16("rstmid.req.cpu_rdata", b1.cpu_rdata, 16'h3C3C);

        // WAIT_CYCLES=0, CPU read held across acks: one access every 3 cycles
        do_reset();
        b0.cpu_rd = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk1($sformatf("w0.c%0d.mem_rd", c), b0.mem_rd, (c % 3) == 1);
            chk1($sformatf("w0.c%0d.cpu_ack", c), b0.cpu_ack, (c % 3) == 2);
            @(posedge clk);
            #1;
        end
        b0.cpu_rd = 1'b0;

        // Randomized traffic against the reference model
        do_reset();
        m_have = 1'b0; m_g = 0; m_own = 1'b0; m_wr = 1'b0; m_byt = 1'b0;
        m_last = 1'b1; m_addr = 16'h0; m_wdata = 16'h0;
        m_rdata[0] = 16'h0; m_rdata[1] = 16'h0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit active, eack_c, eack_d, el_c, el_d;
            b1.cpu_rd    = ($urandom_range(0, 2) == 0);
            b1.cpu_wr    = ($urandom_range(0, 3) == 0);
            b1.cpu_byt   = 1'($urandom_range(0, 1));
            b1.cpu_addr  = 16'($urandom);
            b1.cpu_wdata = 16'($urandom);
            b1.dev_req   = ($urandom_range(0, 1) == 0);
            b1.dev_we    = 1'($urandom_range(0, 1));
            b1.dev_byt   = 1'($urandom_range(0, 1));
            b1.dev_addr  = 16'($urandom);
            b1.dev_wdata = 16'($urandom);
            b1.mem_rdata = 16'($urandom);

            active = m_have && (cyc >= m_g + 1) && (cyc <= m_g + W + 1);
            eack_c = m_have && (cyc == m_g + W + 2) && !m_own;
            eack_d = m_have && (cyc == m_g + W + 2) && m_own;

            @(negedge clk);
            chk1($sformatf("rnd%0d.mem_rd", cyc), b1.mem_rd, active && !m_wr);
            chk1($sformatf("rnd%0d.mem_wr", cyc), b1.mem_wr, active && m_wr);
            chk1($sformatf("rnd%0d.cpu_ack", cyc), b1.cpu_ack, eack_c);
            chk1($sformatf("rnd%0d.dev_ack", cyc), b1.dev_ack, eack_d);
            chk1($sformatf("rnd%0d.dev_gnt", cyc), b1.dev_gnt, active && m_own);
            chk1($sformatf("rnd%0d.cpu_stall", cyc), b1.cpu_stall,
                 (b1.cpu_rd || b1.cpu_wr) && !eack_c);
            chk16($sformatf("rnd%0d.cpu_rdata", cyc), b1.cpu_rdata, m_rdata[0]);
            chk16($sformatf("rnd%0d.dev_rdata", cyc), b1.dev_rdata, m_rdata[1]);
            if (active) begin
                chk16($sformatf("rnd%0d.mem_addr", cyc), b1.mem_addr, m_addr);
                chk16($sformatf("rnd%0d.mem_wdata", cyc), b1.mem_wdata, m_wdata);
                chk1($sformatf("rnd%0d.mem_byt", cyc), b1.mem_byt, m_byt);
            end

            // Advance the model across the coming clock edge
            if (active && (cyc == m_g + W + 1) && !m_wr) m_rdata[m_own] = b1.mem_rdata;
            if (!active) begin
                el_c = (b1.cpu_rd || b1.cpu_wr) && !eack_c;
                el_d = b1.dev_req && !eack_d;
                if (el_c || el_d) begin
                    if (el_c && el_d) m_own = RR ? !m_last : 1'b0;
                    else              m_own = el_d;
                    m_last  = m_own;
                    m_have  = 1'b1;
                    m_g     = cyc;
                    m_wr    = m_own ? b1.dev_we    : b1.cpu_wr;
                    m_addr  = m_own ? b1.dev_addr  : b1.cpu_addr;
                    m_wdata = m_own ? b1.dev_wdata : b1.cpu_wdata;
                    m_byt   = m_own ? b1.dev_byt   : b1.cpu_byt;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
